// File: rtl/branch_pred_ctrl_if.sv
// Fetch-side prediction and execute-side resolution signals between the core
// pipeline (master) and the branch predictor (slave).
interface branch_pred_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      i_if_pc;
  logic             o_if_pred_taken;
  logic [31:0]      o_if_pred_target;

  logic             i_ex_valid;
  logic             i_ex_stall;
  logic             i_ex_is_branch;
  logic             i_ex_is_jump;
  logic [31:0]      i_ex_pc;
  logic             i_ex_taken;
  logic [31:0]      i_ex_target;
  logic             i_ex_pred_taken;
  logic [31:0]      i_ex_pred_target;

  logic             o_flush;
  logic [31:0]      o_redirect_pc;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_miss_cnt;

  modport master (
    output i_if_pc,
    input  o_if_pred_taken, o_if_pred_target,
    output i_ex_valid, i_ex_stall, i_ex_is_branch, i_ex_is_jump, i_ex_pc,
    output i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    input  o_flush, o_redirect_pc, o_br_cnt, o_miss_cnt
  );

  modport slave (
    input  i_if_pc,
    output o_if_pred_taken, o_if_pred_target,
    input  i_ex_valid, i_ex_stall, i_ex_is_branch, i_ex_is_jump, i_ex_pc,
    input  i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    output o_flush, o_redirect_pc, o_br_cnt, o_miss_cnt
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Direct-mapped BTB + 2-bit BHT branch predictor with execute-stage
// misprediction detection, redirect, table training and statistics.
module branch_pred_ctrl #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  branch_pred_ctrl_if.slave   bp
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             jmp;
  } btb_entry_t;

  // Table storage
  logic [DEPTH-1:0] btb_valid;
  btb_entry_t       btb_mem [DEPTH];
  logic [1:0]       bht     [DEPTH];

  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             if_pred_taken;

  assign if_idx        = bp.i_if_pc[IDX_W+1:2];
  assign if_tag        = bp.i_if_pc[31:IDX_W+2];
  assign if_hit        = btb_valid[if_idx] && (btb_mem[if_idx].tag == if_tag);
  assign if_pred_taken = if_hit && (btb_mem[if_idx].jmp || bht[if_idx][1]);

  assign bp.o_if_pred_taken  = if_pred_taken;
  assign bp.o_if_pred_target = if_pred_taken ? btb_mem[if_idx].target
                                             : bp.i_if_pc + 32'd4;

  // Execute-side resolution; an instruction flagged as both branch and jump
  // is treated purely as a jump.
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             res;
  logic             miss;
  logic             ex_jump;
  logic             ex_branch;
  logic             bht_wr;
  logic             btb_wr;
  logic [1:0]       bht_next;

  assign ex_idx    = bp.i_ex_pc[IDX_W+1:2];
  assign ex_tag    = bp.i_ex_pc[31:IDX_W+2];
  assign ex_jump   = bp.i_ex_is_jump;
  assign ex_branch = bp.i_ex_is_branch && !bp.i_ex_is_jump;
  assign res       = bp.i_ex_valid && !bp.i_ex_stall && (ex_branch || ex_jump);
  assign miss      = (bp.i_ex_taken != bp.i_ex_pred_taken) ||
                     (bp.i_ex_taken && (bp.i_ex_target != bp.i_ex_pred_target));
  assign bht_wr    = res && ex_branch;
  assign btb_wr    = res && (ex_jump || bp.i_ex_taken);

  assign bp.o_flush       = res && miss;
  assign bp.o_redirect_pc = bp.i_ex_taken ? bp.i_ex_target : bp.i_ex_pc + 32'd4;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    bht_next = bht[ex_idx];
    if (bp.i_ex_taken) begin
      if (bht[ex_idx] != 2'b11) bht_next = bht[ex_idx] + 2'b01;
    end else begin
      if (bht[ex_idx] != 2'b00) bht_next = bht[ex_idx] - 2'b01;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, which is also what gives fetch the no-bypass view of a
  // same-cycle table update.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      btb_valid <= '0;
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (res) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (miss)   miss_cnt          <= miss_cnt + CNT_W'(1);
      if (bht_wr) bht[ex_idx]       <= bht_next;
      if (btb_wr) btb_valid[ex_idx] <= 1'b1;
    end
  end

  // NOTE: the BTB payload is plain storage with no reset; the reset-cleared
  // valid bits are what keep stale tags and targets from ever being used.
  always_ff @(posedge i_clk) begin
    if (btb_wr) begin
      btb_mem[ex_idx] <= '{tag: ex_tag, target: bp.i_ex_target, jmp: ex_jump};
    end
  end

  assign bp.o_br_cnt   = br_cnt;
  assign bp.o_miss_cnt = miss_cnt;

  // Word-aligned PCs: the byte-offset bits carry no index or tag information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.i_if_pc[1:0], bp.i_ex_pc[1:0]};

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_branch_pred_ctrl;

  localparam int IDX_W = 6;
  localparam int CNT_W = 32;
  localparam int DEPTH = 1 << IDX_W;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  branch_pred_ctrl_if #(.CNT_W(CNT_W)) bp ();

  branch_pred_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bp      (bp)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each slot remembers the full PC of the instruction
  // that last wrote it; BHT strength is a plain 0..3 integer.
  bit          m_valid [DEPTH];
  logic [31:0] m_owner [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  bit          m_jmp   [DEPTH];
  int          m_bht   [DEPTH];
  int unsigned m_br;
  int unsigned m_miss;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
    return (a >> (IDX_W + 2)) == (b >> (IDX_W + 2));
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    int k;
    k = idx_of(pc);
    return m_valid[k] && same_tag(m_owner[k], pc) && (m_jmp[k] || m_bht[k] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return exp_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit exp_res();
    return bp.i_ex_valid && !bp.i_ex_stall && (bp.i_ex_is_branch || bp.i_ex_is_jump);
  endfunction

  function automatic bit exp_miss();
    return (bp.i_ex_taken != bp.i_ex_pred_taken) ||
           (bp.i_ex_taken && bp.i_ex_target != bp.i_ex_pred_target);
  endfunction

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] <= 1'b0;
        m_bht[i]   <= 1;
      end
      m_br   <= 0;
      m_miss <= 0;
    end else if (exp_res()) begin
      m_br <= m_br + 1;
      if (exp_miss()) m_miss <= m_miss + 1;
      if (bp.i_ex_is_jump || bp.i_ex_taken) begin
        m_valid[idx_of(bp.i_ex_pc)] <= 1'b1;
        m_owner[idx_of(bp.i_ex_pc)] <= bp.i_ex_pc;
        m_tgt[idx_of(bp.i_ex_pc)]   <= bp.i_ex_target;
        m_jmp[idx_of(bp.i_ex_pc)]   <= bp.i_ex_is_jump;
      end
      if (!bp.i_ex_is_jump) begin
        if (bp.i_ex_taken) m_bht[idx_of(bp.i_ex_pc)] <= (m_bht[idx_of(bp.i_ex_pc)] >= 3) ? 3 : m_bht[idx_of(bp.i_ex_pc)] + 1;
        else               m_bht[idx_of(bp.i_ex_pc)] <= (m_bht[idx_of(bp.i_ex_pc)] <= 0) ? 0 : m_bht[idx_of(bp.i_ex_pc)] - 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("m_pred_taken", 32'(bp.o_if_pred_taken), 32'(exp_taken(bp.i_if_pc)));
      check("m_pred_target", bp.o_if_pred_target, exp_target(bp.i_if_pc));
      check("m_flush", 32'(bp.o_flush), 32'(exp_res() && exp_miss()));
      if (exp_res() && exp_miss())
        check("m_redirect", bp.o_redirect_pc, bp.i_ex_taken ? bp.i_ex_target : bp.i_ex_pc + 32'd4);
      check("m_br_cnt", bp.o_br_cnt, m_br);
      check("m_miss_cnt", bp.o_miss_cnt, m_miss);
    end
  end

  task automatic ex_drive(input bit v, input bit st, input bit br, input bit jp,
                          input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                          input bit ptk, input logic [31:0] ptg);
    bp.i_ex_valid       = v;
    bp.i_ex_stall       = st;
    bp.i_ex_is_branch   = br;
    bp.i_ex_is_jump     = jp;
    bp.i_ex_pc          = pc;
    bp.i_ex_taken       = tk;
    bp.i_ex_target      = tg;
    bp.i_ex_pred_taken  = ptk;
    bp.i_ex_pred_target = ptg;
  endtask

  task automatic ex_idle();
    ex_drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic to_post();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_flush(input string name, input bit f, input logic [31:0] rd);
    check({name, "_flush"}, 32'(bp.o_flush), 32'(f));
    if (f) check({name, "_redirect"}, bp.o_redirect_pc, rd);
  endtask

  task automatic chk_pred(input string name, input bit t, input logic [31:0] tg);
    check({name, "_taken"}, 32'(bp.o_if_pred_taken), 32'(t));
    check({name, "_target"}, bp.o_if_pred_target, tg);
  endtask

  task automatic chk_cnt(input string name, input int unsigned br, input int unsigned ms);
    check({name, "_br_cnt"}, bp.o_br_cnt, br);
    check({name, "_miss_cnt"}, bp.o_miss_cnt, ms);
  endtask

  initial begin
    bp.i_if_pc = 32'h100;
    ex_idle();
    repeat (2) @(posedge i_clk);
    #1;
    chk_pred("in_reset", 1'b0, 32'h104);
    chk_cnt("in_reset", 0, 0);
    #1 i_reset = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    @(negedge i_clk);
    chk_pred("post_reset", 1'b0, 32'h104);
    chk_cnt("post_reset", 0, 0);
    to_post();

    // First taken BEQ at 0x100 -> 0x80, predicted not taken
    ex_drive(1, 0, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    @(negedge i_clk);
    chk_flush("beq1", 1'b1, 32'h80);
    chk_pred("beq1_no_bypass", 1'b0, 32'h104);
    to_post();
    ex_idle();
    @(negedge i_clk);
    chk_cnt("beq1", 1, 1);
    chk_pred("beq1_learned", 1'b1, 32'h80);
    to_post();

    // Correctly predicted taken, then four more to saturate
    for (int i = 0; i < 5; i++) begin
      ex_drive(1, 0, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80);
      @(negedge i_clk);
      chk_flush("beq_hit", 1'b0, 32'h0);
      to_post();
    end
    ex_idle();
    @(negedge i_clk);
    chk_cnt("beq_sat", 6, 1);
    to_post();

    // Two not-takens from saturated: 11 -> 10 -> 01
    for (int i = 0; i < 2; i++) begin
      ex_drive(1, 0, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
      @(negedge i_clk);
      chk_flush("beq_nt", 1'b1, 32'h104);
      to_post();
    end
    ex_idle();
    @(negedge i_clk);
    chk_pred("beq_weak_nt", 1'b0, 32'h104);
    chk_cnt("beq_nt", 8, 3);
    to_post();

    // JALR at 0x200 (same slot as 0x100): first to 0x300, then moved to 0x340
    ex_drive(1, 0, 0, 1, 32'h200, 1, 32'h300, 0, 32'h204);
    @(negedge i_clk);
    chk_flush("jalr1", 1'b1, 32'h300);
    to_post();
    ex_drive(1, 0, 0, 1, 32'h200, 1, 32'h340, 1, 32'h300);
    @(negedge i_clk);
    chk_flush("jalr2", 1'b1, 32'h340);
    to_post();
    ex_idle();
    bp.i_if_pc = 32'h200;
    @(negedge i_clk);
    chk_pred("jalr_btb", 1'b1, 32'h340);
    chk_cnt("jalr", 10, 5);
    to_post();
    bp.i_if_pc = 32'h100;
    @(negedge i_clk);
    chk_pred("jalr_evicts", 1'b0, 32'h104);
    to_post();

    // Aliasing: 0x100 and 0x200 both taken; the later write owns the slot
    ex_drive(1, 0, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    @(negedge i_clk);
    chk_flush("alias_a", 1'b1, 32'h80);
    to_post();
    ex_drive(1, 0, 1, 0, 32'h200, 1, 32'h500, 0, 32'h204);
    @(negedge i_clk);
    chk_flush("alias_b", 1'b1, 32'h500);
    to_post();
    ex_idle();
    bp.i_if_pc = 32'h100;
    @(negedge i_clk);
    chk_pred("alias_miss", 1'b0, 32'h104);
    to_post();
    bp.i_if_pc = 32'h200;
    @(negedge i_clk);
    chk_pred("alias_owner", 1'b1, 32'h500);
    chk_cnt("alias", 12, 7);
    to_post();

    // Stall for three cycles on a mispredicting not-taken branch
    ex_drive(1, 1, 1, 0, 32'h40, 0, 32'h80, 1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk_flush("stall", 1'b0, 32'h0);
      chk_cnt("stall", 12, 7);
      to_post();
    end
    bp.i_ex_stall = 1'b0;
    @(negedge i_clk);
    chk_flush("stall_release", 1'b1, 32'h44);
    to_post();
    ex_idle();
    bp.i_if_pc = 32'h40;
    @(negedge i_clk);
    chk_cnt("stall_release", 13, 8);
    chk_pred("stall_nt_no_btb", 1'b0, 32'h44);
    to_post();

    // Bubble carrying a taken branch: ignored
    ex_drive(0, 0, 1, 0, 32'h100, 1, 32'h900, 0, 32'h104);
    @(negedge i_clk);
    chk_flush("bubble", 1'b0, 32'h0);
    to_post();
    ex_idle();
    @(negedge i_clk);
    chk_cnt("bubble", 13, 8);
    to_post();

    // Branch and jump both flagged: jump semantics
    ex_drive(1, 0, 1, 1, 32'h400, 1, 32'h600, 0, 32'h404);
    @(negedge i_clk);
    chk_flush("both", 1'b1, 32'h600);
    to_post();
    ex_idle();
    bp.i_if_pc = 32'h400;
    @(negedge i_clk);
    chk_pred("both_jmp", 1'b1, 32'h600);
    chk_cnt("both", 14, 9);
    to_post();

    // Direction right, target wrong
    ex_drive(1, 0, 1, 0, 32'h400, 1, 32'h700, 1, 32'h600);
    @(negedge i_clk);
    chk_flush("tgt_miss", 1'b1, 32'h700);
    to_post();
    // Correct not-taken: target input irrelevant
    ex_drive(1, 0, 1, 0, 32'h400, 0, 32'h123, 0, 32'h404);
    @(negedge i_clk);
    chk_flush("nt_hit", 1'b0, 32'h0);
    to_post();
    ex_idle();
    @(negedge i_clk);
    chk_pred("tgt_updated", 1'b1, 32'h700);
    chk_cnt("tgt", 16, 10);
    to_post();

    // Reset mid-run with a resolving mispredict in EX
    ex_drive(1, 0, 1, 0, 32'h80, 1, 32'h900, 0, 32'h84);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    chk_cnt("async_rst", 0, 0);
    chk_pred("async_rst", 1'b0, 32'h404);
    to_post();
    chk_cnt("rst_edge_discard", 0, 0);
    #2 i_reset = 1'b1;
    ex_idle();
    bp.i_if_pc = 32'h80;
    @(negedge i_clk);
    chk_cnt("after_rst", 0, 0);
    chk_pred("after_rst", 1'b0, 32'h84);
    to_post();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
